// File: rtl/matrix_wb_sequencer.sv
// Serialises a 2x2 matrix result into the register file through the W-stage write port,
// yielding to regular writebacks and holding fetch/decode stalled while elements drain.
module matrix_wb_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int N_ELEM = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mat_valid,
    output logic                       mat_ready,
    input  logic [N_ELEM*DATA_W-1:0]   mat_data,
    input  logic [ADDR_W-1:0]          rd_base,
    input  logic                       regwrite_w,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_wa,
    output logic [DATA_W-1:0]          rf_wd,
    output logic                       matrix_write_in_progress,
    output logic                       mat_done
);

    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [N_ELEM*DATA_W-1:0]  data_lat;
    logic [ADDR_W-1:0]         base_lat;

    logic [ADDR_W-1:0]         target;
    logic [DATA_W-1:0]         elem;
    logic                      issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            mat_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mat_done <= 1'b0;
                    if (mat_valid) begin
                        state <= BUSY;
                        idx   <= '0;
                    end
                end
                BUSY: begin
                    // A W-stage writeback owns the port this cycle; the element waits.
                    if (!regwrite_w) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state    <= DONE;
                            mat_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    mat_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mat_done <= 1'b0;
                end
            endcase
        end
    end

    // Matrix payload is only meaningful while BUSY, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && mat_valid) begin
            data_lat <= mat_data;
            base_lat <= rd_base;
        end
    end

    always_comb begin
        // Destination wraps within the register file; a slot landing on R0 is dropped.
        target = base_lat + ADDR_W'(idx);
        elem   = data_lat[DATA_W*idx +: DATA_W];
        issue  = (state == BUSY) && !regwrite_w;
        rf_we  = issue && (target != '0);
        rf_wa  = rf_we ? target : '0;
        rf_wd  = rf_we ? elem   : '0;
    end

    assign mat_ready                = (state == IDLE);
    assign matrix_write_in_progress = (state == BUSY) || ((state == IDLE) && mat_valid);

endmodule

// File: tb/tb_matrix_wb_sequencer.sv
// Bench for matrix_wb_sequencer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on logged outputs.
module tb_matrix_wb_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int N_ELEM = 4;
    localparam int LOGN   = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        mat_valid;
    logic        mat_ready;
    logic [31:0] mat_data;
    logic [2:0]  rd_base;
    logic        regwrite_w;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic [7:0]  rf_wd;
    logic        mwip;
    logic        mat_done;

    always #5 clk = ~clk;

    matrix_wb_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_ELEM(N_ELEM)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .mat_valid                (mat_valid),
        .mat_ready                (mat_ready),
        .mat_data                 (mat_data),
        .rd_base                  (rd_base),
        .regwrite_w               (regwrite_w),
        .rf_we                    (rf_we),
        .rf_wa                    (rf_wa),
        .rf_wd                    (rf_wd),
        .matrix_write_in_progress (mwip),
        .mat_done                 (mat_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       we_log    [LOGN];
    logic [2:0] wa_log    [LOGN];
    logic [7:0] wd_log    [LOGN];
    logic       done_log  [LOGN];
    logic       ready_log [LOGN];
    logic       mwip_log  [LOGN];

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t q[$];
    bit  m_done = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Reference model: a matrix becomes a queue of (address, data) slots.
    always @(negedge clk) begin
        logic       e_ready, e_we, e_done, e_mwip, idle;
        logic [2:0] e_wa;
        logic [7:0] e_wd;
        e_we = 1'b0; e_wa = '0; e_wd = '0;
        if (rst) begin
            q.delete();
            m_done  = 1'b0;
            e_ready = 1'b1;
            e_done  = 1'b0;
            e_mwip  = mat_valid;
        end else begin
            idle    = (q.size() == 0) && !m_done;
            e_ready = idle;
            e_done  = m_done;
            e_mwip  = (q.size() != 0) || (idle && mat_valid);
            if (q.size() != 0 && !regwrite_w && q[0].a != 3'd0) begin
                e_we = 1'b1;
                e_wa = q[0].a;
                e_wd = q[0].d;
            end
        end
        check("mat_ready", 32'(mat_ready), 32'(e_ready));
        check("rf_we",     32'(rf_we),     32'(e_we));
        check("rf_wa",     32'(rf_wa),     32'(e_wa));
        check("rf_wd",     32'(rf_wd),     32'(e_wd));
        check("mat_done",  32'(mat_done),  32'(e_done));
        check("mwip",      32'(mwip),      32'(e_mwip));
        if (cyc < LOGN) begin
            we_log[cyc]    = rf_we;
            wa_log[cyc]    = rf_wa;
            wd_log[cyc]    = rf_wd;
            done_log[cyc]  = mat_done;
            ready_log[cyc] = mat_ready;
            mwip_log[cyc]  = mwip;
        end
        if (!rst) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (q.size() != 0) begin
                if (!regwrite_w) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1'b1;
                end
            end else if (mat_valid) begin
                for (int i = 0; i < N_ELEM; i++) begin
                    wr_t w;
                    w.a = rd_base + 3'(i);
                    w.d = mat_data[8*i +: 8];
                    q.push_back(w);
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int t;
        rst = 1'b1; mat_valid = 1'b0; regwrite_w = 1'b0; mat_data = '0; rd_base = '0;
        idle_cycles(2);
        rst = 1'b0;
        t = cyc;
        regwrite_w = 1'b1;
        tick();
        regwrite_w = 1'b0;
        idle_cycles(1);
        check("rst_ready", 32'(ready_log[t]), 32'd1);
        check("rst_we",    32'(we_log[t]),    32'd0);
        check("rst_done",  32'(done_log[t]),  32'd0);

        // Basic sequence
        t = cyc; mat_valid = 1'b1; rd_base = 3'd3; mat_data = 32'h44332211;
        tick(); mat_valid = 1'b0;
        idle_cycles(7);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'h11 * 8'(i + 1);
            check("basic_we", 32'(we_log[t+1+i]), 32'd1);
            check("basic_wa", 32'(wa_log[t+1+i]), 32'(3 + i));
            check("basic_wd", 32'(wd_log[t+1+i]), 32'(d));
            check("basic_mwip", 32'(mwip_log[t+i]), 32'd1);
        end
        check("basic_mwip4", 32'(mwip_log[t+4]), 32'd1);
        check("basic_mwip5", 32'(mwip_log[t+5]), 32'd0);
        check("basic_done4", 32'(done_log[t+4]), 32'd0);
        check("basic_done5", 32'(done_log[t+5]), 32'd1);
        check("basic_done6", 32'(done_log[t+6]), 32'd0);
        check("basic_ready6", 32'(ready_log[t+6]), 32'd1);

        // Address wrap through R0
        t = cyc; mat_valid = 1'b1; rd_base = 3'd6; mat_data = 32'hDDCCBBAA;
        tick(); mat_valid = 1'b0;
        idle_cycles(7);
        check("wrap_wa1", 32'(wa_log[t+1]), 32'd6);
        check("wrap_wd1", 32'(wd_log[t+1]), 32'hAA);
        check("wrap_wa2", 32'(wa_log[t+2]), 32'd7);
        check("wrap_wd2", 32'(wd_log[t+2]), 32'hBB);
        check("wrap_we3", 32'(we_log[t+3]), 32'd0);
        check("wrap_wd3", 32'(wd_log[t+3]), 32'd0);
        check("wrap_wa4", 32'(wa_log[t+4]), 32'd1);
        check("wrap_wd4", 32'(wd_log[t+4]), 32'hDD);
        check("wrap_done5", 32'(done_log[t+5]), 32'd1);

        // Yield to W stage in T+2 and T+3
        t = cyc; mat_valid = 1'b1; rd_base = 3'd1; mat_data = 32'h87654321;
        tick(); mat_valid = 1'b0;
        tick(); regwrite_w = 1'b1;
        tick();
        tick(); regwrite_w = 1'b0;
        idle_cycles(6);
        check("yield_we1", 32'(we_log[t+1]), 32'd1);
        check("yield_wd1", 32'(wd_log[t+1]), 32'h21);
        check("yield_we2", 32'(we_log[t+2]), 32'd0);
        check("yield_we3", 32'(we_log[t+3]), 32'd0);
        check("yield_wa4", 32'(wa_log[t+4]), 32'd2);
        check("yield_wd4", 32'(wd_log[t+4]), 32'h43);
        check("yield_wd5", 32'(wd_log[t+5]), 32'h65);
        check("yield_wa6", 32'(wa_log[t+6]), 32'd4);
        check("yield_wd6", 32'(wd_log[t+6]), 32'h87);
        check("yield_done6", 32'(done_log[t+6]), 32'd0);
        check("yield_done7", 32'(done_log[t+7]), 32'd1);

        // Reset mid-sequence
        t = cyc; mat_valid = 1'b1; rd_base = 3'd2; mat_data = 32'h5A5A5A5A;
        tick(); mat_valid = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        idle_cycles(5);
        check("rstmid_we1", 32'(we_log[t+1]), 32'd1);
        check("rstmid_we2", 32'(we_log[t+2]), 32'd0);
        check("rstmid_ready2", 32'(ready_log[t+2]), 32'd1);
        for (int i = 3; i < 8; i++) check("rstmid_nowrite", 32'(we_log[t+i]), 32'd0);
        t = cyc; mat_valid = 1'b1; rd_base = 3'd4; mat_data = 32'h0A0B0C0D;
        tick(); mat_valid = 1'b0;
        idle_cycles(7);
        check("after_rst_wa1", 32'(wa_log[t+1]), 32'd4);
        check("after_rst_wd1", 32'(wd_log[t+1]), 32'h0D);
        check("after_rst_wd4", 32'(wd_log[t+4]), 32'h0A);
        check("after_rst_done5", 32'(done_log[t+5]), 32'd1);

        // Back-to-back with mat_valid held
        t = cyc; mat_valid = 1'b1; rd_base = 3'd5; mat_data = 32'h11223344;
        idle_cycles(7);
        mat_valid = 1'b0;
        idle_cycles(8);
        for (int i = 1; i <= 5; i++) check("b2b_ready_low", 32'(ready_log[t+i]), 32'd0);
        check("b2b_ready6", 32'(ready_log[t+6]), 32'd1);
        check("b2b_mwip5", 32'(mwip_log[t+5]), 32'd0);
        check("b2b_mwip6", 32'(mwip_log[t+6]), 32'd1);
        check("b2b_we7",  32'(we_log[t+7]), 32'd1);
        check("b2b_wa7",  32'(wa_log[t+7]), 32'd5);
        check("b2b_wd7",  32'(wd_log[t+7]), 32'h44);
        check("b2b_done11", 32'(done_log[t+11]), 32'd1);
        for (int i = 0; i < 5; i++) check("b2b_mwip_hi", 32'(mwip_log[t+i]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
